muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Parametrised iterative multiply/divide unit; successor to the separate fixed-width Mult and Div blocks.
//  One datapath covers MULT, MULTU, DIV and DIVU, selected by an op input.
//  Start/busy/done handshake, cancel, and a divide-by-zero flag.
//  Results feed the CPU HI/LO registers: HI = product high or remainder; LO = product low or quotient.
// PARAMETERS
//  WIDTH  32  operand width in bits, >= 2; the product is 2*WIDTH bits (hi:lo)
//  CNT_W  $clog2(WIDTH+1)  localparam, width of the iteration counter
// PORTS
//  clk       in   1      clock, rising edge
//  reset     in   1      asynchronous, active-low reset
//  start     in   1      request; sampled only when busy=0
//  cancel    in   1      abort the current operation
//  op        in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
//  a         in   WIDTH  multiplicand / dividend; sampled with start
//  b         in   WIDTH  multiplier / divisor; sampled with start
//  busy      out  1      operation in progress
//  done      out  1      one-cycle pulse: result valid (or div_zero)
//  div_zero  out  1      one-cycle pulse, coincident with done; divisor was 0
//  hi        out  WIDTH  product[2W-1:W] or remainder; held until the next completion
//  lo        out  WIDTH  product[W-1:0] or quotient; held until the next completion
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; busy, done, div_zero, hi, lo and the counter all 0.
//  FSM states:
//   IDLE: start=1 latches op, |a|, |b| (signed ops only) and the result-sign bits.
//         Then -> CALC with busy=1 next cycle.
//         Division with b==0 -> DZ instead of CALC.
//   CALC: one radix-2 step per cycle, WIDTH cycles, counter counts WIDTH-1 down to 0.
//         Multiply: shift-add on a 2W accumulator.
//         Divide: restoring step; 2W remainder/quotient shift register, unsigned compare/subtract.
//         Counter reaching 0 -> FIX.
//   FIX:  conditional two's-complement negate.
//         Signed mult: product negated if sign(a)^sign(b).
//         Signed div: quotient negated if sign(a)^sign(b); remainder takes the sign of the dividend.
//         Writes hi/lo, pulses done, busy=0 -> IDLE.
//   DZ:   pulses done and div_zero; hi/lo unchanged; busy=0 -> IDLE.
//  Latency, start cycle = T:
//   mult/div: done at T+WIDTH+2, busy high T+1..T+WIDTH+1.
//   div by 0: done at T+2.
//   Back-to-back: start may be asserted in the done cycle.
//  Signed division truncates toward zero.
//   MIN / -1 gives quotient = MIN, remainder = 0; falls out of the abs arithmetic, no flag.
//  start while busy=1: ignored, no queuing.
//  cancel=1 while busy: -> IDLE next cycle, no done, hi/lo unchanged. cancel in IDLE: no effect.
//  cancel and start in the same IDLE cycle: start wins.
//  hi/lo change only in FIX, so they are stable to the CPU between operations.
//  All arithmetic is unsigned on WIDTH/2*WIDTH vectors. Sign handling happens only at entry and in FIX.
// STRUCTURE
//  Package muldiv_pkg: op encoding (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and FSM state enum.
//  One natural sub-module: muldiv_negate.
//   Parametrised conditional two's-complement negate.
//   Instantiated for operand abs values and for result fix-up.
//  FSM, counter and accumulators stay in muldiv_unit.
// TESTING (WIDTH=32; latency checked on every case)
//  MULT a=FFFFFFFD (-3), b=00000007 -> done at T+34, hi=FFFFFFFF, lo=FFFFFFEB.
//  MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
//  DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1).
//  DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000, div_zero=0.
//  DIVU a=5, b=0 after a prior result -> done and div_zero at T+2, hi/lo keep the prior values.
//  MULTU 6*7, start re-pulsed at T+5 with new operands -> ignored, lo=0000002A.
//   Next run: cancel at T+10 -> no done, busy=0 at T+11.
//   Next run: reset low mid-CALC -> all outputs 0 immediately.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op encoding, FSM states and op-decode helpers for the multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10,
      ST_DZ   = 2'b11
   } state_e;

   // True for the two division ops.
   function automatic logic op_is_div(input op_e op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // True for the two signed ops.
   function automatic logic op_is_signed(input op_e op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module muldiv_negate #(
   parameter int unsigned W = 32
) (
   input  logic         en_i,
   input  logic [W-1:0] val_i,
   output logic [W-1:0] res_c_o
);

   // Negate when enabled, otherwise pass through.
   always_comb begin
      res_c_o = val_i;
      if (en_i) begin
         res_c_o = ~val_i + W'(1);
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit (MULT, MULTU, DIV, DIVU) producing HI/LO results.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             cancel,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned W2    = 2 * WIDTH;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [W2-1:0]      acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic               is_div_q, is_div_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   op_e                op_c;
   logic               signed_c;
   logic               div_c;
   logic [WIDTH-1:0]   a_abs_c;
   logic [WIDTH-1:0]   b_abs_c;
   logic [WIDTH:0]     mul_sum_c;
   logic [W2-1:0]      mul_next_c;
   logic [WIDTH:0]     div_tmp_c;
   logic               div_ge_c;
   logic [WIDTH-1:0]   div_rem_c;
   logic [W2-1:0]      div_next_c;
   logic [W2-1:0]      prod_fix_c;
   logic [WIDTH-1:0]   quo_fix_c;
   logic [WIDTH-1:0]   rem_fix_c;

   assign op_c     = op_e'(op);
   assign signed_c = op_is_signed(op_c);
   assign div_c    = op_is_div(op_c);

   // Operand magnitudes for the signed ops.
   muldiv_negate #(.W(WIDTH)) u_neg_a (
      .en_i    (signed_c & a[WIDTH-1]),
      .val_i   (a),
      .res_c_o (a_abs_c)
   );

   muldiv_negate #(.W(WIDTH)) u_neg_b (
      .en_i    (signed_c & b[WIDTH-1]),
      .val_i   (b),
      .res_c_o (b_abs_c)
   );

   // Result sign fix-up: full product, quotient and remainder.
   muldiv_negate #(.W(W2)) u_neg_prod (
      .en_i    (neg_res_q),
      .val_i   (acc_q),
      .res_c_o (prod_fix_c)
   );

   muldiv_negate #(.W(WIDTH)) u_neg_quo (
      .en_i    (neg_res_q),
      .val_i   (acc_q[WIDTH-1:0]),
      .res_c_o (quo_fix_c)
   );

   muldiv_negate #(.W(WIDTH)) u_neg_rem (
      .en_i    (neg_rem_q),
      .val_i   (acc_q[W2-1:WIDTH]),
      .res_c_o (rem_fix_c)
   );

   // Shift-add multiply step: multiplier in the low half, partial product shifts in from the top.
   assign mul_sum_c  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opnd_q};
   assign mul_next_c = acc_q[0] ? {mul_sum_c, acc_q[WIDTH-1:1]} : {1'b0, acc_q[W2-1:1]};

   // Restoring divide step: shifted partial remainder may carry one bit past WIDTH.
   assign div_tmp_c  = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
   assign div_ge_c   = div_tmp_c[WIDTH] | (div_tmp_c[WIDTH-1:0] >= opnd_q);
   assign div_rem_c  = div_ge_c ? (div_tmp_c[WIDTH-1:0] - opnd_q) : div_tmp_c[WIDTH-1:0];
   assign div_next_c = {div_rem_c, acc_q[WIDTH-2:0], div_ge_c};

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dz_q      <= dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      dz_d      = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               is_div_d  = div_c;
               neg_res_d = signed_c & (a[WIDTH-1] ^ b[WIDTH-1]);
               neg_rem_d = signed_c & a[WIDTH-1];
               cnt_d     = CNT_W'(WIDTH - 1);
               busy_d    = 1'b1;
               if (div_c) begin
                  opnd_d = b_abs_c;
                  acc_d  = {{WIDTH{1'b0}}, a_abs_c};
               end else begin
                  opnd_d = a_abs_c;
                  acc_d  = {{WIDTH{1'b0}}, b_abs_c};
               end
               state_d = (div_c && (b == '0)) ? ST_DZ : ST_CALC;
            end
         end
         ST_CALC: begin
            if (cancel) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               acc_d = is_div_q ? div_next_c : mul_next_c;
               if (cnt_q == '0) begin
                  state_d = ST_FIX;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         ST_FIX: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
            if (!cancel) begin
               done_d = 1'b1;
               if (is_div_q) begin
                  hi_d = rem_fix_c;
                  lo_d = quo_fix_c;
               end else begin
                  hi_d = prod_fix_c[W2-1:WIDTH];
                  lo_d = prod_fix_c[WIDTH-1:0];
               end
            end
         end
         ST_DZ: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
            if (!cancel) begin
               done_d = 1'b1;
               dz_d   = 1'b1;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: timeline reference model plus directed literal checks.
module tb_muldiv_unit;

   localparam int unsigned WIDTH = 32;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              cancel;
   logic [1:0]        op;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic              busy;
   logic              done;
   logic              div_zero;
   logic [WIDTH-1:0]  hi;
   logic [WIDTH-1:0]  lo;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state: expected outputs for the current cycle.
   int               cyc = 0;
   bit               inflight = 0;
   int               done_at = 0;
   bit               pend_dz = 0;
   logic [WIDTH-1:0] pend_hi = '0;
   logic [WIDTH-1:0] pend_lo = '0;
   bit               exp_busy = 0;
   bit               exp_done = 0;
   bit               exp_dz = 0;
   logic [WIDTH-1:0] exp_hi = '0;
   logic [WIDTH-1:0] exp_lo = '0;

   muldiv_unit #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .reset    (rst_n),
      .start    (start),
      .cancel   (cancel),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Architectural result of one operation, from plain 64-bit arithmetic.
   function automatic void model_calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                      output logic [31:0] rh, output logic [31:0] rl, output bit dz);
      longint      sx, sy;
      logic [63:0] p;
      logic [63:0] q;
      logic [63:0] r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      dz = 1'b0;
      rh = '0;
      rl = '0;
      case (o)
         2'b00: begin p = 64'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
         2'b01: begin p = {32'b0, x} * {32'b0, y}; rh = p[63:32]; rl = p[31:0]; end
         2'b10: begin
            if (y == 0) dz = 1'b1;
            else begin q = 64'(sx / sy); r = 64'(sx % sy); rl = q[31:0]; rh = r[31:0]; end
         end
         default: begin
            if (y == 0) dz = 1'b1;
            else begin rl = x / y; rh = x % y; end
         end
      endcase
   endfunction

   // Timeline model: accept, cancel and completion decided from the inputs seen each cycle.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            inflight = 0; exp_busy = 0; exp_done = 0; exp_dz = 0;
            exp_hi = '0; exp_lo = '0;
         end else begin
            bit nb, nd, nz;
            nb = 0; nd = 0; nz = 0;
            if (inflight && exp_busy && cancel) begin
               inflight = 0;
            end else if (inflight && (cyc + 1 == done_at)) begin
               nd = 1; nz = pend_dz;
               if (!pend_dz) begin exp_hi = pend_hi; exp_lo = pend_lo; end
               inflight = 0;
            end else if (inflight) begin
               nb = 1;
            end
            if (!exp_busy && start) begin
               model_calc(op, a, b, pend_hi, pend_lo, pend_dz);
               inflight = 1;
               done_at  = cyc + (pend_dz ? 2 : int'(WIDTH) + 2);
               nb = 1;
            end
            exp_busy = nb; exp_done = nd; exp_dz = nz;
            cyc++;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            vectors++;
            if (busy !== exp_busy || done !== exp_done || div_zero !== exp_dz ||
                hi !== exp_hi || lo !== exp_lo) begin
               miscompares++;
               $display("FAIL cyc %0d outputs: busy %b want %b, done %b want %b, div_zero %b want %b, hi %h want %h, lo %h want %h",
                        cyc, busy, exp_busy, done, exp_done, div_zero, exp_dz, hi, exp_hi, lo, exp_lo);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Present a start for one cycle; returns the start cycle index.
   task automatic drive_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int t);
      t = cyc;
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Wait (bounded) for done and check its latency from the start cycle.
   task automatic wait_done(input string name, input int t0, input int lat);
      int n = 0;
      while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      check({name, "_latency"}, 32'(cyc - t0), 32'(lat));
   endtask

   initial begin
      int t, t2, ndone, n;
      start = 0; cancel = 0; op = 0; a = 0; b = 0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_busy", 32'(busy), 0);
      check("reset_done", 32'(done), 0);
      check("reset_dz", 32'(div_zero), 0);
      check("reset_hi", hi, 0);
      check("reset_lo", lo, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick(2);

      drive_start(2'b00, 32'hFFFFFFFD, 32'h00000007, t);
      wait_done("mult_neg", t, 34);
      check("mult_neg_hi", hi, 32'hFFFFFFFF);
      check("mult_neg_lo", lo, 32'hFFFFFFEB);
      tick(1);

      drive_start(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, t);
      wait_done("multu_max", t, 34);
      check("multu_max_hi", hi, 32'hFFFFFFFE);
      check("multu_max_lo", lo, 32'h00000001);
      tick(1);

      drive_start(2'b10, 32'h80000000, 32'hFFFFFFFF, t);
      wait_done("div_min", t, 34);
      check("div_min_lo", lo, 32'h80000000);
      check("div_min_hi", hi, 32'h00000000);
      check("div_min_dz", 32'(div_zero), 0);
      tick(1);

      drive_start(2'b10, 32'hFFFFFFF9, 32'h00000002, t);
      wait_done("div_neg", t, 34);
      check("div_neg_lo", lo, 32'hFFFFFFFD);
      check("div_neg_hi", hi, 32'hFFFFFFFF);
      tick(1);

      drive_start(2'b11, 32'h5, 32'h0, t);
      wait_done("divu_zero", t, 2);
      check("divu_zero_dz", 32'(div_zero), 1);
      check("divu_zero_hi", hi, 32'hFFFFFFFF);
      check("divu_zero_lo", lo, 32'hFFFFFFFD);

      // Started in the done cycle; re-pulsed start at T+5 must be ignored.
      drive_start(2'b01, 32'd6, 32'd7, t);
      tick(4);
      drive_start(2'b01, 32'd9, 32'd9, t2);
      check("repulse_cycle", 32'(t2 - t), 5);
      wait_done("multu_67", t, 34);
      check("multu_67_lo", lo, 32'h0000002A);
      check("multu_67_hi", hi, 32'h00000000);

      // Cancel at T+10: idle at T+11, results held, no done.
      drive_start(2'b01, 32'd123, 32'd456, t);
      tick(9);
      cancel = 1'b1;
      tick(1);
      cancel = 1'b0;
      check("cancel_cycle", 32'(cyc - t), 11);
      check("cancel_busy", 32'(busy), 0);
      check("cancel_lo", lo, 32'h0000002A);
      ndone = 0;
      repeat (40) begin @(negedge clk); if (done === 1'b1) ndone++; end
      check("cancel_no_done", 32'(ndone), 0);
      tick(1);

      // Randomised operations, cancels, ignored starts and back-to-back issue.
      for (int i = 0; i < 150; i++) begin
         logic [1:0]  ro;
         logic [31:0] ra, rb;
         int mode, off;
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: rb = 32'($urandom_range(0, 15));
            2: ra = 32'h80000000;
            3: rb = 32'hFFFFFFFF;
            default: ;
         endcase
         mode = $urandom_range(0, 4);
         off  = $urandom_range(0, 35);
         if (mode == 3) cancel = 1'b1;
         drive_start(ro, ra, rb, t);
         cancel = 1'b0;
         tick(off);
         if (mode == 1) begin cancel = 1'b1; tick(1); cancel = 1'b0; end
         if (mode == 2) drive_start(2'($urandom_range(0, 3)), $urandom, $urandom, t2);
         n = 0;
         while (inflight && n < 200) begin tick(1); n++; end
         if (inflight) begin
            vectors++; miscompares++;
            $display("FAIL random_timeout: op %0d still in flight after %0d cycles", i, n);
         end
         tick($urandom_range(0, 2));
      end

      // Reset in the middle of a calculation clears all outputs at once.
      drive_start(2'b00, 32'h12345678, 32'h9ABCDEF0, t);
      tick(5);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 0);
      check("midrst_done", 32'(done), 0);
      check("midrst_dz", 32'(div_zero), 0);
      check("midrst_hi", hi, 0);
      check("midrst_lo", lo, 0);
      tick(2);
      rst_n = 1'b1;
      tick(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
